// File: rtl/axi_pkg.sv
// Shared AXI definitions for the default slave: bus widths,
// response codes and the write/read FSM state encodings.
package axi_pkg;

   localparam int AXI_IDS_BITS   = 8;
   localparam int AXI_ADDR_BITS  = 32;
   localparam int AXI_LEN_BITS   = 4;
   localparam int AXI_SIZE_BITS  = 3;
   localparam int AXI_BURST_BITS = 2;
   localparam int AXI_DATA_BITS  = 32;
   localparam int AXI_STRB_BITS  = 4;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wstate_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rstate_t;

endpackage

// File: rtl/axi_default_slave_if.sv
// AXI4 slave-port signal bundle for the default slave,
// with master and slave views of every channel.
interface axi_default_slave_if;
   import axi_pkg::*;

   logic [AXI_IDS_BITS-1:0]   AWID_S;
   logic [AXI_ADDR_BITS-1:0]  AWADDR_S;
   logic [AXI_LEN_BITS-1:0]   AWLEN_S;
   logic [AXI_SIZE_BITS-1:0]  AWSIZE_S;
   logic [AXI_BURST_BITS-1:0] AWBURST_S;
   logic                      AWVALID_S;
   logic                      AWREADY_S;

   logic [AXI_DATA_BITS-1:0]  WDATA_S;
   logic [AXI_STRB_BITS-1:0]  WSTRB_S;
   logic                      WLAST_S;
   logic                      WVALID_S;
   logic                      WREADY_S;

   logic [AXI_IDS_BITS-1:0]   BID_S;
   logic [1:0]                BRESP_S;
   logic                      BVALID_S;
   logic                      BREADY_S;

   logic [AXI_IDS_BITS-1:0]   ARID_S;
   logic [AXI_ADDR_BITS-1:0]  ARADDR_S;
   logic [AXI_LEN_BITS-1:0]   ARLEN_S;
   logic [AXI_SIZE_BITS-1:0]  ARSIZE_S;
   logic [AXI_BURST_BITS-1:0] ARBURST_S;
   logic                      ARVALID_S;
   logic                      ARREADY_S;

   logic [AXI_IDS_BITS-1:0]   RID_S;
   logic [AXI_DATA_BITS-1:0]  RDATA_S;
   logic [1:0]                RRESP_S;
   logic                      RLAST_S;
   logic                      RVALID_S;
   logic                      RREADY_S;

   modport slave (
      input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
      output AWREADY_S,
      input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
      output WREADY_S,
      output BID_S, BRESP_S, BVALID_S,
      input  BREADY_S,
      input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
      output ARREADY_S,
      output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
      input  RREADY_S
   );

   modport master (
      output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
      input  AWREADY_S,
      output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
      input  WREADY_S,
      input  BID_S, BRESP_S, BVALID_S,
      output BREADY_S,
      output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
      input  ARREADY_S,
      input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
      output RREADY_S
   );

endinterface

// File: rtl/axi_default_slave_rd.sv
// Read side of the default slave: AR acceptance, beat counting
// and DECERR read beats carrying a fixed data pattern.
module axi_default_slave_rd
   import axi_pkg::*;
#(
   parameter logic [AXI_DATA_BITS-1:0] RDATA_PATTERN = 32'h0000_0000
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic [AXI_IDS_BITS-1:0]  arid,
   input  logic [AXI_LEN_BITS-1:0]  arlen,
   input  logic                     arvalid,
   output logic                     arready,
   output logic [AXI_IDS_BITS-1:0]  rid,
   output logic [AXI_DATA_BITS-1:0] rdata,
   output logic [1:0]               rresp,
   output logic                     rlast,
   output logic                     rvalid,
   input  logic                     rready
);

   rstate_t                  r_state;
   rstate_t                  r_next;
   logic [AXI_LEN_BITS-1:0]  len_q;
   logic [AXI_LEN_BITS-1:0]  cnt_q;
   logic                     ar_hs;
   logic                     at_last;

   assign ar_hs   = (r_state == R_IDLE) && arvalid;
   assign at_last = (cnt_q == len_q);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state <= R_IDLE;
         rid     <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
      end else begin
         r_state <= r_next;
         if (ar_hs) begin
            rid   <= arid;
            len_q <= arlen;
            cnt_q <= '0;
         end else if (r_state == R_DATA && rready && !at_last) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE: if (arvalid) r_next = R_DATA;
         R_DATA: if (rready && at_last) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // all outputs decode from registered state only
   assign arready = (r_state == R_IDLE);
   assign rvalid  = (r_state == R_DATA);
   assign rlast   = (r_state == R_DATA) && at_last;
   assign rdata   = RDATA_PATTERN;
   assign rresp   = DECERR;

endmodule

// File: rtl/axi_default_slave.sv
// Default AXI slave for unmapped space: completes every burst
// with DECERR, discards write data and returns a fixed read pattern.
module axi_default_slave
   import axi_pkg::*;
#(
   parameter logic [AXI_DATA_BITS-1:0] RDATA_PATTERN = 32'h0000_0000
) (
   input  logic               ACLK,
   input  logic               ARESET,
   axi_default_slave_if.slave s
);

   wstate_t                  w_state;
   wstate_t                  w_next;
   logic [AXI_IDS_BITS-1:0]  bid_q;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state <= W_IDLE;
         bid_q   <= '0;
      end else begin
         w_state <= w_next;
         if (w_state == W_IDLE && s.AWVALID_S)
            bid_q <= s.AWID_S;
      end
   end

   // burst end comes from WLAST; AWLEN is not tracked
   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE: if (s.AWVALID_S) w_next = W_DATA;
         W_DATA: if (s.WVALID_S && s.WLAST_S) w_next = W_RESP;
         W_RESP: if (s.BREADY_S) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   assign s.AWREADY_S = (w_state == W_IDLE);
   assign s.WREADY_S  = (w_state == W_DATA);
   assign s.BVALID_S  = (w_state == W_RESP);
   assign s.BID_S     = bid_q;
   assign s.BRESP_S   = DECERR;

   axi_default_slave_rd #(
      .RDATA_PATTERN (RDATA_PATTERN)
   ) u_rd (
      .ACLK    (ACLK),
      .ARESET  (ARESET),
      .arid    (s.ARID_S),
      .arlen   (s.ARLEN_S),
      .arvalid (s.ARVALID_S),
      .arready (s.ARREADY_S),
      .rid     (s.RID_S),
      .rdata   (s.RDATA_S),
      .rresp   (s.RRESP_S),
      .rlast   (s.RLAST_S),
      .rvalid  (s.RVALID_S),
      .rready  (s.RREADY_S)
   );

   logic unused_fields;
   assign unused_fields = ^{s.AWADDR_S, s.AWLEN_S, s.AWSIZE_S,
                            s.AWBURST_S, s.WDATA_S, s.WSTRB_S,
                            s.ARADDR_S, s.ARSIZE_S, s.ARBURST_S};

endmodule
